// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: instruction classes, branch func3 codes, ALU control
// encodings and the EX/MEM pipeline register layout.
package riscv_pkg;

    localparam logic [3:0] OP_R      = 4'd0;
    localparam logic [3:0] OP_I      = 4'd1;
    localparam logic [3:0] OP_LOAD   = 4'd2;
    localparam logic [3:0] OP_STORE  = 4'd3;
    localparam logic [3:0] OP_BRANCH = 4'd4;
    localparam logic [3:0] OP_JAL    = 4'd5;
    localparam logic [3:0] OP_JALR   = 4'd6;
    localparam logic [3:0] OP_LUI    = 4'd7;
    localparam logic [3:0] OP_AUIPC  = 4'd8;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_SR   = 3'b101;

    // ALU control is {func7b5, func3}
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic [3:0]  opclass;
        logic [2:0]  func3;
        logic        misalign;
    } exmem_t;

    function automatic logic [3:0] branch_alu_ctl(input logic [2:0] f3);
        logic [3:0] ctl;
        case (f3)
            F3_BEQ, F3_BNE:   ctl = ALU_SUB;
            F3_BLT, F3_BGE:   ctl = ALU_SLT;
            F3_BLTU, F3_BGEU: ctl = ALU_SLTU;
            default:          ctl = ALU_ADD;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/riscv_branch_unit.sv
// Branch/jump resolution: taken decision from the shared ALU flags plus a private
// target adder, and misalignment of the taken target.
module riscv_branch_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      opclass,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] imm,
    input  logic            alu_lsb,
    input  logic            alu_zero,
    output logic            taken,
    output logic [XLEN-1:0] target,
    output logic            misalign
);

    logic            cond_s;
    logic [XLEN-1:0] base_s;
    logic [XLEN-1:0] sum_s;

    // branch condition from SUB zero flag or SLT/SLTU result bit
    always_comb begin
        cond_s = 1'b0;
        case (func3)
            F3_BEQ:           cond_s = alu_zero;
            F3_BNE:           cond_s = ~alu_zero;
            F3_BLT, F3_BLTU:  cond_s = alu_lsb;
            F3_BGE, F3_BGEU:  cond_s = ~alu_lsb;
            default:          cond_s = 1'b0;
        endcase
    end

    // target adder; JALR clears bit 0 of rs1+imm
    always_comb begin
        if (opclass == OP_JALR) begin
            base_s = rs1;
        end else begin
            base_s = pc;
        end
        sum_s = base_s + imm;
        if (opclass == OP_JALR) begin
            target = {sum_s[XLEN-1:1], 1'b0};
        end else begin
            target = sum_s;
        end
    end

    // taken decision per instruction class
    always_comb begin
        taken = 1'b0;
        case (opclass)
            OP_BRANCH:      taken = cond_s;
            OP_JAL, OP_JALR: taken = 1'b1;
            default:        taken = 1'b0;
        endcase
        misalign = taken & target[1];
    end

endmodule

// File: rtl/riscv_ex_stage.sv
// RV32I execute stage: drives the external ALU, resolves control flow and holds the
// EX/MEM pipeline register behind a valid/ready handshake.
module riscv_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_opclass,
    input  logic [2:0]      in_func3,
    input  logic            in_func7b5,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    input  logic [4:0]      in_rd,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_func3,
    output logic            alu_func7,
    input  logic [XLEN-1:0] alu_out,
    input  logic            alu_zero,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_store_data,
    output logic [4:0]      out_rd,
    output logic [3:0]      out_opclass,
    output logic [2:0]      out_func3,
    output logic            out_misalign,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    logic            xfer_s;
    logic            taken_s;
    logic            misalign_s;
    logic [XLEN-1:0] target_s;
    logic [XLEN-1:0] link_s;
    logic [XLEN-1:0] result_s;
    logic [4:0]      rd_s;

    // the slot after a redirect is wrong-path and must be refused
    assign in_ready = (~out_valid | out_ready) & ~redirect_valid;
    assign xfer_s   = in_valid & in_ready;
    assign link_s   = in_pc + {{(XLEN-3){1'b0}}, 3'd4};

    // operand and ALU control selection per instruction class
    always_comb begin
        alu_a     = in_rs1;
        alu_b     = in_imm;
        alu_func3 = 3'b000;
        alu_func7 = 1'b0;
        rd_s      = in_rd;
        case (in_opclass)
            OP_R: begin
                alu_b     = in_rs2;
                alu_func3 = in_func3;
                alu_func7 = in_func7b5;
            end
            OP_I: begin
                alu_func3 = in_func3;
                if (in_func3 == F3_SR) begin
                    alu_func7 = in_func7b5;
                end else begin
                    alu_func7 = 1'b0;
                end
            end
            OP_LOAD, OP_JALR: begin
                alu_a = in_rs1;
            end
            OP_STORE: begin
                rd_s = 5'd0;
            end
            OP_AUIPC, OP_JAL: begin
                alu_a = in_pc;
            end
            OP_LUI: begin
                alu_a = {XLEN{1'b0}};
            end
            OP_BRANCH: begin
                alu_b                  = in_rs2;
                {alu_func7, alu_func3} = branch_alu_ctl(in_func3);
                rd_s                   = 5'd0;
            end
            default: begin
                rd_s = 5'd0;
            end
        endcase
    end

    // jumps write back the link address instead of the ALU sum
    always_comb begin
        if ((in_opclass == OP_JAL) || (in_opclass == OP_JALR)) begin
            result_s = link_s;
        end else begin
            result_s = alu_out;
        end
    end

    riscv_branch_unit #(.XLEN(XLEN)) u_branch (
        .opclass  (in_opclass),
        .func3    (in_func3),
        .pc       (in_pc),
        .rs1      (in_rs1),
        .imm      (in_imm),
        .alu_lsb  (alu_out[0]),
        .alu_zero (alu_zero),
        .taken    (taken_s),
        .target   (target_s),
        .misalign (misalign_s)
    );

    // EX/MEM register: load on transfer, drain on out_ready, otherwise hold
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid      <= 1'b0;
            out_result     <= {XLEN{1'b0}};
            out_store_data <= {XLEN{1'b0}};
            out_rd         <= 5'd0;
            out_opclass    <= 4'd0;
            out_func3      <= 3'd0;
            out_misalign   <= 1'b0;
        end else if (xfer_s) begin
            out_valid      <= 1'b1;
            out_result     <= result_s;
            out_store_data <= in_rs2;
            out_rd         <= rd_s;
            out_opclass    <= in_opclass;
            out_func3      <= in_func3;
            out_misalign   <= misalign_s;
        end else if (out_ready) begin
            out_valid      <= 1'b0;
        end else begin
            out_valid      <= out_valid;
        end
    end

    // one-cycle redirect pulse for every accepted taken branch/jump
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= {XLEN{1'b0}};
        end else begin
            redirect_valid <= xfer_s & taken_s;
            if (xfer_s & taken_s) begin
                redirect_pc <= target_s;
            end else begin
                redirect_pc <= redirect_pc;
            end
        end
    end

endmodule

// File: tb/tb_riscv_ex_stage.sv
// Self-checking bench for riscv_ex_stage: directed scenarios plus randomized traffic
// against an instruction-level reference model and a behavioural ALU.
module tb_riscv_ex_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, in_func7b5;
    logic [3:0]  in_opclass;
    logic [2:0]  in_func3;
    logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
    logic [4:0]  in_rd;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [2:0]  alu_func3;
    logic        alu_func7, alu_zero;
    logic        out_valid, out_ready, out_misalign, redirect_valid;
    logic [31:0] out_result, out_store_data, redirect_pc;
    logic [4:0]  out_rd;
    logic [3:0]  out_opclass;
    logic [2:0]  out_func3;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [31:0] a, b, result, store_data, target;
        logic [3:0]  ctl, opclass;
        logic [2:0]  func3;
        logic [4:0]  rd;
        logic        taken, mis;
    } exp_t;

    exp_t        q[$];
    logic        m_redir    = 1'b0;
    logic [31:0] m_redir_pc = 32'd0;

    always #5 clk = ~clk;

    riscv_ex_stage dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_opclass(in_opclass),
        .in_func3(in_func3), .in_func7b5(in_func7b5), .in_pc(in_pc),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_rd(in_rd),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func3(alu_func3), .alu_func7(alu_func7),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_store_data(out_store_data), .out_rd(out_rd), .out_opclass(out_opclass),
        .out_func3(out_func3), .out_misalign(out_misalign),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    function automatic logic [31:0] alu_sem(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (ctl)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << sh;
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return $unsigned($signed(a) >>> sh);
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return 32'd0;
        endcase
    endfunction

    // behavioural ALU standing in for the core's shared ALU
    always_comb begin
        alu_out  = alu_sem({alu_func7, alu_func3}, alu_a, alu_b);
        alu_zero = (alu_out == 32'd0);
    end

    function automatic exp_t ref_model(input logic [3:0] op, input logic [2:0] f3, input logic f7,
                                       input logic [31:0] pc, input logic [31:0] rs1,
                                       input logic [31:0] rs2, input logic [31:0] imm,
                                       input logic [4:0] rd);
        exp_t e;
        e.a = rs1; e.b = imm; e.ctl = ALU_ADD; e.rd = rd; e.taken = 1'b0; e.target = 32'd0;
        e.store_data = rs2; e.opclass = op; e.func3 = f3; e.result = rs1 + imm;
        case (op)
            OP_R: begin
                e.b = rs2; e.ctl = {f7, f3}; e.result = alu_sem(e.ctl, rs1, rs2);
            end
            OP_I: begin
                e.ctl = {(f3 == 3'b101) ? f7 : 1'b0, f3}; e.result = alu_sem(e.ctl, rs1, imm);
            end
            OP_LOAD:  e.result = rs1 + imm;
            OP_STORE: e.rd = 5'd0;
            OP_AUIPC: begin e.a = pc; e.result = pc + imm; end
            OP_LUI:   begin e.a = 32'd0; e.result = imm; end
            OP_JAL: begin
                e.a = pc; e.result = pc + 32'd4; e.taken = 1'b1; e.target = pc + imm;
            end
            OP_JALR: begin
                e.result = pc + 32'd4; e.taken = 1'b1; e.target = (rs1 + imm) & 32'hFFFF_FFFE;
            end
            OP_BRANCH: begin
                e.b = rs2; e.rd = 5'd0; e.target = pc + imm;
                case (f3)
                    3'b000: begin e.ctl = ALU_SUB;  e.taken = (rs1 == rs2); end
                    3'b001: begin e.ctl = ALU_SUB;  e.taken = (rs1 != rs2); end
                    3'b100: begin e.ctl = ALU_SLT;  e.taken = ($signed(rs1) <  $signed(rs2)); end
                    3'b101: begin e.ctl = ALU_SLT;  e.taken = ($signed(rs1) >= $signed(rs2)); end
                    3'b110: begin e.ctl = ALU_SLTU; e.taken = (rs1 <  rs2); end
                    3'b111: begin e.ctl = ALU_SLTU; e.taken = (rs1 >= rs2); end
                    default: begin e.ctl = ALU_ADD; e.taken = 1'b0; end
                endcase
                e.result = alu_sem(e.ctl, rs1, rs2);
            end
            default: e.rd = 5'd0;
        endcase
        e.mis = e.taken & e.target[1];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic set_instr(input logic [3:0] op, input logic [2:0] f3, input logic f7,
                             input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [31:0] imm, input logic [4:0] rd);
        in_opclass = op; in_func3 = f3; in_func7b5 = f7; in_pc = pc;
        in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_rd = rd;
    endtask

    // one clock: check everything at the falling edge, then advance the model
    task automatic step();
        exp_t e;
        logic exp_rdy;
        @(negedge clk);
        e = ref_model(in_opclass, in_func3, in_func7b5, in_pc, in_rs1, in_rs2, in_imm, in_rd);
        exp_rdy = ((q.size() == 0) || out_ready) && !m_redir;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (in_valid) begin
            chk("alu_a", alu_a, e.a);
            chk("alu_b", alu_b, e.b);
            chk("alu_ctl", 32'({alu_func7, alu_func3}), 32'(e.ctl));
        end
        if (q.size() != 0) begin
            chk("out_valid", 32'(out_valid), 32'd1);
            chk("out_result", out_result, q[0].result);
            chk("out_store_data", out_store_data, q[0].store_data);
            chk("out_rd", 32'(out_rd), 32'(q[0].rd));
            chk("out_opclass", 32'(out_opclass), 32'(q[0].opclass));
            chk("out_func3", 32'(out_func3), 32'(q[0].func3));
            chk("out_misalign", 32'(out_misalign), 32'(q[0].mis));
        end else begin
            chk("out_valid_idle", 32'(out_valid), 32'd0);
        end
        chk("redirect_valid", 32'(redirect_valid), 32'(m_redir));
        if (m_redir) chk("redirect_pc", redirect_pc, m_redir_pc);
        if ((q.size() != 0) && out_ready) void'(q.pop_front());
        m_redir    = in_valid && exp_rdy && e.taken;
        m_redir_pc = e.target;
        if (in_valid && exp_rdy) q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [31:0] r1;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_instr(OP_R, 3'b000, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_redirect", 32'(redirect_valid), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        // ADD rs1=5 rs2=7
        set_instr(OP_R, 3'b000, 1'b0, 32'h0, 32'd5, 32'd7, 32'd0, 5'd3); in_valid = 1'b1;
        #1; chk("add_ctl", 32'({alu_func7, alu_func3}), 32'h0);
        step(); in_valid = 1'b0;
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_result", out_result, 32'd12);
        chk("add_rd", 32'(out_rd), 32'd3);
        step();

        // SRAI
        set_instr(OP_I, 3'b101, 1'b1, 32'h4, 32'h8000_0000, 32'd0, 32'h404, 5'd5); in_valid = 1'b1;
        #1; chk("srai_ctl", 32'({alu_func7, alu_func3}), 32'hD);
        step(); in_valid = 1'b0;
        chk("srai_result", out_result, 32'hF800_0000);
        step();

        // BEQ taken, then a wrong-path offer that must be refused
        set_instr(OP_BRANCH, 3'b000, 1'b0, 32'h100, 32'd3, 32'd3, 32'h20, 5'd7); in_valid = 1'b1;
        step();
        chk("beq_redirect", 32'(redirect_valid), 32'd1);
        chk("beq_target", redirect_pc, 32'h120);
        chk("beq_in_ready", 32'(in_ready), 32'd0);
        chk("beq_rd", 32'(out_rd), 32'd0);
        set_instr(OP_R, 3'b000, 1'b0, 32'h104, 32'd1, 32'd1, 32'd0, 5'd4);
        step();
        chk("beq_pulse_end", 32'(redirect_valid), 32'd0);
        step(); in_valid = 1'b0; step();
        // BEQ not taken
        set_instr(OP_BRANCH, 3'b000, 1'b0, 32'h100, 32'd3, 32'd4, 32'h20, 5'd7); in_valid = 1'b1;
        step(); in_valid = 1'b0;
        chk("bne_no_redirect", 32'(redirect_valid), 32'd0);
        step();

        // JALR with misaligned target
        set_instr(OP_JALR, 3'b000, 1'b0, 32'h40, 32'h1001, 32'd0, 32'd2, 5'd1); in_valid = 1'b1;
        step(); in_valid = 1'b0;
        chk("jalr_redirect", 32'(redirect_valid), 32'd1);
        chk("jalr_target", redirect_pc, 32'h1002);
        chk("jalr_link", out_result, 32'h44);
        chk("jalr_misalign", 32'(out_misalign), 32'd1);
        step(); step();

        // back-pressure for 3 cycles with a second instruction waiting
        out_ready = 1'b0;
        set_instr(OP_R, 3'b000, 1'b0, 32'h80, 32'd10, 32'd20, 32'd0, 5'd9); in_valid = 1'b1;
        step();
        set_instr(OP_I, 3'b000, 1'b0, 32'h84, 32'd100, 32'd0, 32'd1, 5'd10);
        repeat (3) step();
        chk("stall_hold_rd", 32'(out_rd), 32'd9);
        out_ready = 1'b1;
        step(); in_valid = 1'b0;
        chk("stall_next_rd", 32'(out_rd), 32'd10);
        chk("stall_next_res", out_result, 32'd101);
        step(); step();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            op = 4'($urandom_range(0, 9));
            f3 = 3'($urandom_range(0, 7));
            f7 = 1'($urandom_range(0, 1));
            if ((op == OP_R) && (f3 != 3'b000) && (f3 != 3'b101)) f7 = 1'b0;
            r1 = $urandom;
            set_instr(op, f3, f7, $urandom & 32'hFFFF_FFFC, r1,
                      ($urandom_range(0, 3) == 0) ? r1 : $urandom, $urandom, 5'($urandom));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step(); step();

        // asynchronous reset with an instruction held and a redirect pending
        out_ready = 1'b0;
        set_instr(OP_JAL, 3'b000, 1'b0, 32'h200, 32'd0, 32'd0, 32'h10, 5'd2); in_valid = 1'b1;
        step(); in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_redirect", 32'(redirect_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_redirect", 32'(redirect_valid), 32'd0);
        chk("mid_rst_result", out_result, 32'd0);
        q.delete(); m_redir = 1'b0;
        @(negedge clk); reset_n = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
